// File: rtl/drive_ramp_ctrl.sv
// drive_ramp_ctrl: CH-channel PWM motor drive. Duty ramps toward a latched
// per-channel target by RAMP_STEP on each prescaler tick.
// Ports: CLK_50M/Reset (async, active-low), cmd/cmd_valid/tgt_bus (mode and
// target latch), pwm_out, duty_bus (current duty), busy, state_o.
// Optional: define DRIVE_RAMP_WATCHDOG_EN to add a command watchdog
// (WDT_TICKS ticks without cmd_valid forces STOP) and the wdt_trip output.
module drive_ramp_ctrl #(
  parameter int CH        = 2,
  parameter int PWM_BITS  = 10,
  parameter int TICK_DIV  = 50000,
  parameter int RAMP_STEP = 8,
  parameter int WDT_TICKS = 500
) (
  input  logic                   CLK_50M,
  input  logic                   Reset,
  input  logic [1:0]             cmd,
  input  logic                   cmd_valid,
  input  logic [CH*PWM_BITS-1:0] tgt_bus,
  output logic [CH-1:0]          pwm_out,
  output logic [CH*PWM_BITS-1:0] duty_bus,
  output logic                   busy,
  output logic [1:0]             state_o
`ifdef DRIVE_RAMP_WATCHDOG_EN
  ,
  output logic                   wdt_trip
`endif
);

  localparam int PW = PWM_BITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] M_STOP  = 2'b00;
  localparam logic [1:0] M_RUN   = 2'b01;
  localparam logic [1:0] M_BRAKE = 2'b10;
  localparam logic [1:0] M_HOLD  = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RAMP   = 2'b01;
  localparam logic [1:0] S_AT     = 2'b10;
  localparam logic [1:0] S_FROZEN = 2'b11;

  localparam logic [PW:0]   STEP    = (PW+1)'(RAMP_STEP);
  localparam logic [PW-1:0] PC_LAST = PW'((1 << PW) - 2);
  localparam logic [TW-1:0] PRE_END = TW'(TICK_DIV - 1);

  logic [TW-1:0] pre_q, pre_d;
  logic          tick;
  logic [PW-1:0] pc_q, pc_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] tgt_q [CH];
  logic [PW-1:0] tgt_d [CH];
  logic [PW-1:0] cur_q [CH];
  logic [PW-1:0] cur_d [CH];
  logic [PW-1:0] sh_q  [CH];
  logic [PW-1:0] sh_d  [CH];
  logic [CH-1:0] pwm_q, pwm_d;
  logic          brake;
  logic          all_zero;
  logic          any_diff;
  logic [PW:0]   c1, e1, up;
  logic [PW-1:0] e_n, cmpv;

  assign tick = (pre_q == PRE_END);

  always_comb begin
    pre_d = tick ? '0 : pre_q + TW'(1);
    pc_d  = (pc_q == PC_LAST) ? '0 : pc_q + PW'(1);
  end

`ifdef DRIVE_RAMP_WATCHDOG_EN
  localparam int WW = $clog2(WDT_TICKS + 1);
  localparam logic [WW-1:0] WDT_MAX = WW'(WDT_TICKS);
  logic [WW-1:0] wdt_q, wdt_d;
  assign wdt_trip = (wdt_q == WDT_MAX);
`else
  logic unused_wdt;
  assign unused_wdt = ^WDT_TICKS;
`endif

  // Command latch. BRAKE is stored as STOP: its only extra effect is
  // the one-cycle zeroing of every channel.
  always_comb begin
    mode_d = mode_q;
    brake  = 1'b0;
    for (int i = 0; i < CH; i++) tgt_d[i] = tgt_q[i];
    if (cmd_valid) begin
      brake  = (cmd == M_BRAKE);
      mode_d = brake ? M_STOP : cmd;
      if (cmd == M_RUN)
        for (int i = 0; i < CH; i++)
          tgt_d[i] = tgt_bus[i*PW +: PW];
    end
`ifdef DRIVE_RAMP_WATCHDOG_EN
    wdt_d = wdt_q;
    if (cmd_valid)
      wdt_d = '0;
    else if (tick && wdt_q != WDT_MAX)
      wdt_d = wdt_q + WW'(1);
    // Expiry keeps forcing STOP (also over HOLD) until a new command.
    if (!cmd_valid && wdt_d == WDT_MAX)
      mode_d = M_STOP;
`endif
  end

  // Ramp step uses the current (old) mode/target; FSM summary uses the
  // next-cycle values.
  always_comb begin
    all_zero = 1'b1;
    any_diff = 1'b0;
    c1  = '0;
    e1  = '0;
    up  = '0;
    e_n = '0;
    for (int i = 0; i < CH; i++) begin
      c1 = {1'b0, cur_q[i]};
      e1 = (mode_q == M_RUN) ? {1'b0, tgt_q[i]} : '0;
      up = c1 + STEP;
      cur_d[i] = cur_q[i];
      if (tick && (mode_q == M_RUN || mode_q == M_STOP)) begin
        if (c1 < e1)
          cur_d[i] = (up >= e1) ? e1[PW-1:0] : up[PW-1:0];
        else if (c1 > e1)
          cur_d[i] = (c1 <= e1 + STEP) ? e1[PW-1:0]
                                       : c1[PW-1:0] - STEP[PW-1:0];
      end
      if (brake) cur_d[i] = '0;
      e_n = (mode_d == M_RUN) ? tgt_d[i] : '0;
      if (cur_d[i] != '0 || e_n != '0) all_zero = 1'b0;
      if (cur_d[i] != e_n) any_diff = 1'b1;
    end
  end

  always_comb begin
    if (mode_d == M_HOLD)
      state_d = S_FROZEN;
    else if (all_zero)
      state_d = S_IDLE;
    else if (any_diff)
      state_d = S_RAMP;
    else
      state_d = S_AT;
  end

  // At counter 0 the compare uses the freshly loaded duty so each
  // period is aligned to the counter wrap.
  always_comb begin
    cmpv = '0;
    for (int i = 0; i < CH; i++) begin
      cmpv     = (pc_q == '0) ? cur_q[i] : sh_q[i];
      sh_d[i]  = cmpv;
      pwm_d[i] = (pc_q < cmpv);
    end
  end

  always_ff @(posedge CLK_50M or negedge Reset) begin
    if (!Reset) begin
      pre_q   <= '0;
      pc_q    <= '0;
      mode_q  <= M_STOP;
      state_q <= S_IDLE;
      pwm_q   <= '0;
      for (int i = 0; i < CH; i++) begin
        tgt_q[i] <= '0;
        cur_q[i] <= '0;
        sh_q[i]  <= '0;
      end
`ifdef DRIVE_RAMP_WATCHDOG_EN
      wdt_q <= '0;
`endif
    end else begin
      pre_q   <= pre_d;
      pc_q    <= pc_d;
      mode_q  <= mode_d;
      state_q <= state_d;
      pwm_q   <= pwm_d;
      for (int i = 0; i < CH; i++) begin
        tgt_q[i] <= tgt_d[i];
        cur_q[i] <= cur_d[i];
        sh_q[i]  <= sh_d[i];
      end
`ifdef DRIVE_RAMP_WATCHDOG_EN
      wdt_q <= wdt_d;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++)
      duty_bus[i*PW +: PW] = cur_q[i];
  end

  assign pwm_out = pwm_q;
  assign busy    = (state_q == S_RAMP);
  assign state_o = state_q;

endmodule

// File: tb/tb_drive_ramp_ctrl.sv
// tb_drive_ramp_ctrl: directed checks of ramping, modes, PWM shape,
// reset and (when DRIVE_RAMP_WATCHDOG_EN is defined) the watchdog.
module tb_drive_ramp_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT: CH=2, PWM_BITS=10
  logic [1:0]  cmd = 2'b00;
  logic        cv = 1'b0;
  logic [19:0] tgt = '0;
  logic [1:0]  pwm;
  logic [19:0] duty;
  logic        busy;
  logic [1:0]  st;

  // small DUT: CH=1, PWM_BITS=4, RAMP_STEP=15
  logic [1:0]  s_cmd = 2'b00;
  logic        s_cv = 1'b0;
  logic [3:0]  s_tgt = '0;
  logic        s_pwm;
  logic [3:0]  s_duty;
  logic        s_busy;
  logic [1:0]  s_st;

  int pass_cnt = 0;
  int total = 0;
  int n;

  // bench-side edge counter: value k+1 is seen after clock edge k
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else n <= n + 1;

`ifdef DRIVE_RAMP_WATCHDOG_EN
  logic        m_trip, s_trip;
  logic [1:0]  w_cmd = 2'b00;
  logic        w_cv = 1'b0;
  logic [9:0]  w_tgt = '0;
  logic        w_pwm;
  logic [9:0]  w_duty;
  logic        w_busy;
  logic [1:0]  w_st;
  logic        w_trip;

  drive_ramp_ctrl #(.CH(1), .PWM_BITS(10), .TICK_DIV(10),
                    .RAMP_STEP(8), .WDT_TICKS(5)) u_w (
    .CLK_50M(clk), .Reset(rst_n), .cmd(w_cmd), .cmd_valid(w_cv),
    .tgt_bus(w_tgt), .pwm_out(w_pwm), .duty_bus(w_duty),
    .busy(w_busy), .state_o(w_st), .wdt_trip(w_trip));
`endif

  drive_ramp_ctrl #(.CH(2), .PWM_BITS(10), .TICK_DIV(10),
                    .RAMP_STEP(8), .WDT_TICKS(500)) u_m (
    .CLK_50M(clk), .Reset(rst_n), .cmd(cmd), .cmd_valid(cv),
    .tgt_bus(tgt), .pwm_out(pwm), .duty_bus(duty),
    .busy(busy), .state_o(st)
`ifdef DRIVE_RAMP_WATCHDOG_EN
    , .wdt_trip(m_trip)
`endif
  );

  drive_ramp_ctrl #(.CH(1), .PWM_BITS(4), .TICK_DIV(10),
                    .RAMP_STEP(15), .WDT_TICKS(500)) u_s (
    .CLK_50M(clk), .Reset(rst_n), .cmd(s_cmd), .cmd_valid(s_cv),
    .tgt_bus(s_tgt), .pwm_out(s_pwm), .duty_bus(s_duty),
    .busy(s_busy), .state_o(s_st)
`ifdef DRIVE_RAMP_WATCHDOG_EN
    , .wdt_trip(s_trip)
`endif
  );

  task automatic do_reset;
    cv = 0; s_cv = 0; cmd = 0; s_cmd = 0; tgt = '0; s_tgt = '0;
`ifdef DRIVE_RAMP_WATCHDOG_EN
    w_cv = 0; w_cmd = 0; w_tgt = '0;
`endif
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_n(input int target);
    int k = 0;
    while (n != target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (n != target) $display("FAIL wait_n n=%0d want=%0d", n, target);
    else pass_cnt++;
  endtask

  // returns at the negedge right after a tick edge
  task automatic next_tick;
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((n % 10) != 0 && k < 40);
  endtask

  task automatic issue(input logic [1:0] c, input int t0, input int t1);
    cmd = c;
    tgt = {10'(t1), 10'(t0)};
    cv = 1;
    @(negedge clk);
    cv = 0;
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if (duty !== 20'd0) $display("FAIL rst_duty got=%h exp=0", duty);
    else pass_cnt++;
    total++;
    if (pwm !== 2'b00) $display("FAIL rst_pwm got=%b exp=00", pwm);
    else pass_cnt++;
    total++;
    if (st !== 2'b00 || busy !== 1'b0)
      $display("FAIL rst_state got=%b/%b exp=00/0", st, busy);
    else pass_cnt++;
    repeat (25) @(negedge clk);
    total++;
    if (duty !== 20'd0 || st !== 2'b00)
      $display("FAIL rst_idle got=%h/%b exp=0/00", duty, st);
    else pass_cnt++;
  endtask

  task automatic test_ramp_up;
    do_reset();
    issue(2'b01, 20, 100);
    total++;
    if (st !== 2'b01 || busy !== 1'b1)
      $display("FAIL up_start got=%b/%b exp=01/1", st, busy);
    else pass_cnt++;
    next_tick();
    total++;
    if (duty !== {10'd8, 10'd8}) $display("FAIL up_t1 got=%h exp=%h", duty, {10'd8, 10'd8});
    else pass_cnt++;
    next_tick();
    total++;
    if (duty !== {10'd16, 10'd16}) $display("FAIL up_t2 got=%h exp=%h", duty, {10'd16, 10'd16});
    else pass_cnt++;
    next_tick();
    total++;
    if (duty !== {10'd24, 10'd20}) $display("FAIL up_t3 got=%h exp=%h", duty, {10'd24, 10'd20});
    else pass_cnt++;
    repeat (9) next_tick();
    total++;
    if (duty !== {10'd96, 10'd20} || st !== 2'b01 || busy !== 1'b1)
      $display("FAIL up_t12 got=%h/%b/%b exp=%h/01/1", duty, st, busy, {10'd96, 10'd20});
    else pass_cnt++;
    next_tick();
    total++;
    if (duty !== {10'd100, 10'd20} || st !== 2'b10 || busy !== 1'b0)
      $display("FAIL up_t13 got=%h/%b/%b exp=%h/10/0", duty, st, busy, {10'd100, 10'd20});
    else pass_cnt++;
  endtask

  task automatic test_ramp_down;
    int hi;
    do_reset();
    issue(2'b01, 100, 100);
    repeat (13) next_tick();
    total++;
    if (duty !== {10'd100, 10'd100} || st !== 2'b10)
      $display("FAIL dn_top got=%h/%b exp=%h/10", duty, st, {10'd100, 10'd100});
    else pass_cnt++;
    issue(2'b00, 0, 0);
    total++;
    if (st !== 2'b01) $display("FAIL dn_start got=%b exp=01", st);
    else pass_cnt++;
    repeat (12) next_tick();
    total++;
    if (duty !== {10'd4, 10'd4} || st !== 2'b01)
      $display("FAIL dn_t12 got=%h/%b exp=%h/01", duty, st, {10'd4, 10'd4});
    else pass_cnt++;
    next_tick();
    total++;
    if (duty !== 20'd0 || st !== 2'b00 || busy !== 1'b0)
      $display("FAIL dn_t13 got=%h/%b/%b exp=0/00/0", duty, st, busy);
    else pass_cnt++;
    repeat (1100) @(negedge clk);
    hi = 0;
    for (int k = 0; k < 1023; k++) begin
      if (pwm !== 2'b00) hi++;
      @(negedge clk);
    end
    total++;
    if (hi != 0) $display("FAIL dn_pwm_low got=%0d high samples exp=0", hi);
    else pass_cnt++;
  endtask

  task automatic test_brake;
    do_reset();
    issue(2'b01, 200, 200);
    repeat (12) next_tick();
    total++;
    if (duty !== {10'd96, 10'd96}) $display("FAIL brk_pre got=%h exp=%h", duty, {10'd96, 10'd96});
    else pass_cnt++;
    repeat (9) @(negedge clk);
    cmd = 2'b10;
    cv = 1;
    @(negedge clk);
    cv = 0;
    total++;
    if (duty !== 20'd0 || st !== 2'b00 || busy !== 1'b0)
      $display("FAIL brk_zero got=%h/%b/%b exp=0/00/0", duty, st, busy);
    else pass_cnt++;
    next_tick();
    total++;
    if (duty !== 20'd0 || st !== 2'b00)
      $display("FAIL brk_stay got=%h/%b exp=0/00", duty, st);
    else pass_cnt++;
  endtask

  task automatic test_collision;
    do_reset();
    issue(2'b01, 200, 200);
    repeat (2) next_tick();
    repeat (9) @(negedge clk);
    cmd = 2'b00;
    cv = 1;
    @(negedge clk);
    cv = 0;
    total++;
    if (duty !== {10'd24, 10'd24} || st !== 2'b01)
      $display("FAIL col_oldmode got=%h/%b exp=%h/01", duty, st, {10'd24, 10'd24});
    else pass_cnt++;
    next_tick();
    total++;
    if (duty !== {10'd16, 10'd16}) $display("FAIL col_stop got=%h exp=%h", duty, {10'd16, 10'd16});
    else pass_cnt++;
  endtask

  task automatic test_hold;
    do_reset();
    issue(2'b01, 200, 200);
    repeat (6) next_tick();
    issue(2'b11, 0, 0);
    total++;
    if (st !== 2'b11 || busy !== 1'b0)
      $display("FAIL hold_state got=%b/%b exp=11/0", st, busy);
    else pass_cnt++;
    repeat (20) next_tick();
    total++;
    if (duty !== {10'd48, 10'd48} || st !== 2'b11)
      $display("FAIL hold_duty got=%h/%b exp=%h/11", duty, st, {10'd48, 10'd48});
    else pass_cnt++;
    issue(2'b01, 48, 48);
    total++;
    if (st !== 2'b10) $display("FAIL hold_resume got=%b exp=10", st);
    else pass_cnt++;
  endtask

  task automatic test_pwm_shape;
    int ca, cb, cc;
    logic mid_pwm;
    logic [3:0] mid_duty;
    do_reset();
    s_cmd = 2'b01;
    s_tgt = 4'd5;
    s_cv = 1;
    @(negedge clk);
    s_cv = 0;
    wait_n(16);
    ca = 0; cb = 0; cc = 0;
    mid_pwm = 1'b1;
    mid_duty = '0;
    for (int k = 16; k <= 60; k++) begin
      if (k <= 30) ca += int'(s_pwm);
      else if (k <= 45) cb += int'(s_pwm);
      else cc += int'(s_pwm);
      if (k == 32) begin
        s_tgt = 4'd15;
        s_cv = 1;
      end
      if (k == 33) s_cv = 0;
      if (k == 41) begin
        mid_pwm = s_pwm;
        mid_duty = s_duty;
      end
      @(negedge clk);
    end
    total++;
    if (ca != 5) $display("FAIL pwm_d5 got=%0d high exp=5", ca);
    else pass_cnt++;
    total++;
    if (cb != 5) $display("FAIL pwm_midchg got=%0d high exp=5", cb);
    else pass_cnt++;
    total++;
    if (cc != 15) $display("FAIL pwm_d15 got=%0d high exp=15", cc);
    else pass_cnt++;
    total++;
    if (mid_duty !== 4'd15 || mid_pwm !== 1'b0)
      $display("FAIL pwm_shadow got=%0d/%b exp=15/0", mid_duty, mid_pwm);
    else pass_cnt++;
  endtask

`ifdef DRIVE_RAMP_WATCHDOG_EN
  task automatic test_watchdog;
    do_reset();
    w_cmd = 2'b01;
    w_tgt = 10'd100;
    w_cv = 1;
    @(negedge clk);
    w_cv = 0;
    wait_n(49);
    total++;
    if (w_trip !== 1'b0 || w_duty !== 10'd32)
      $display("FAIL wdt_pre got=%b/%0d exp=0/32", w_trip, w_duty);
    else pass_cnt++;
    wait_n(50);
    total++;
    if (w_trip !== 1'b1 || w_duty !== 10'd40 || w_st !== 2'b01)
      $display("FAIL wdt_trip got=%b/%0d/%b exp=1/40/01", w_trip, w_duty, w_st);
    else pass_cnt++;
    wait_n(60);
    total++;
    if (w_duty !== 10'd32) $display("FAIL wdt_rampdn got=%0d exp=32", w_duty);
    else pass_cnt++;
    wait_n(61);
    w_cv = 1;
    @(negedge clk);
    w_cv = 0;
    total++;
    if (w_trip !== 1'b0) $display("FAIL wdt_clear got=%b exp=0", w_trip);
    else pass_cnt++;
    wait_n(70);
    total++;
    if (w_duty !== 10'd40) $display("FAIL wdt_rerun got=%0d exp=40", w_duty);
    else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid;
    do_reset();
    issue(2'b01, 1000, 1000);
    repeat (110) next_tick();
    total++;
    if (pwm !== 2'b11 || st !== 2'b01)
      $display("FAIL rmid_pre got=%b/%b exp=11/01", pwm, st);
    else pass_cnt++;
    #2;
    rst_n = 0;
    #1;
    total++;
    if (duty !== 20'd0 || pwm !== 2'b00 || st !== 2'b00 || busy !== 1'b0)
      $display("FAIL rmid_async got=%h/%b/%b/%b exp=0/00/00/0", duty, pwm, st, busy);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_brake();
    test_collision();
    test_hold();
    test_pwm_shape();
`ifdef DRIVE_RAMP_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/drive_ramp_ctrl.md
Name: drive_ramp_ctrl

Overview:
- Parametrised successor to the fixed-speed drive decode. Generates CH PWM motor channels from a latched per-channel target speed bus and a 2-bit mode command.
- Ramps each channel's duty toward its target by RAMP_STEP per 1 ms tick, which limits acceleration and deceleration.
- Sits between the command/state logic and the motor drivers, and replaces per-motor fixed-speed instances.

Parameters:
- CH, 2, number of motor channels (1..8)
- PWM_BITS, 10, duty/counter width; PWM period = 2^PWM_BITS-1 clocks
- TICK_DIV, 50000, clocks per ramp tick (1 ms at 50 MHz)
- RAMP_STEP, 8, duty change per tick per channel (1..2^PWM_BITS-1)
- WDT_TICKS, 500, watchdog timeout in ticks (used only with WATCHDOG_EN)

Ports:
- CLK_50M  in  1  system clock
- Reset  in  1  asynchronous reset, active-low
- cmd  in  2  mode: 00 STOP (ramp to 0), 01 RUN (ramp to target), 10 BRAKE (immediate 0), 11 HOLD (freeze)
- cmd_valid  in  1  one-cycle strobe; latches cmd and tgt_bus
- tgt_bus  in  CH*PWM_BITS  per-channel target duty; channel i at [i*PWM_BITS +: PWM_BITS]
- pwm_out  out  CH  registered PWM outputs
- duty_bus  out  CH*PWM_BITS  current ramped duty per channel
- busy  out  1  high while any channel's duty differs from its effective target
- state_o  out  2  FSM state: 00 IDLE, 01 RAMP, 10 AT_TGT, 11 FROZEN

Behaviour:
- Reset (async, Reset=0): all outputs 0; latched mode=STOP; targets=0; prescaler, PWM counter, watchdog=0; FSM=IDLE.
- Prescaler: counts 0..TICK_DIV-1. tick is high for one cycle when count==TICK_DIV-1. Free-running; never cleared by commands.
- Command latch: on cmd_valid, mode<=cmd. tgt_bus is latched only for RUN; other modes keep the previous targets. Effective target = latched target in RUN, 0 in STOP/BRAKE.
- Ramp, on tick, for each channel when mode is RUN or STOP:
  - cur<eff: cur<=min(cur+RAMP_STEP, eff).
  - cur>eff: cur<=max(cur-RAMP_STEP, eff).
  - Arithmetic uses PWM_BITS+1 bits, so there is no wrap at the top or below 0.
- HOLD: cur is frozen and ticks are ignored. Latched targets are kept.
- BRAKE: all cur<=0 in the cycle after cmd_valid, regardless of tick. Mode then behaves as STOP.
- Simultaneous cmd_valid and tick: the tick step in that cycle uses the old mode/target. The new command applies from the next cycle. BRAKE is the exception: zero wins over the step.
- FSM (registered, updated every cycle from next-cycle values):
  - FROZEN when mode=HOLD.
  - Else IDLE when all cur==0 and all eff==0.
  - Else RAMP when any cur!=eff.
  - Else AT_TGT.
  - busy = (state==RAMP).
- PWM:
  - Counter runs 0..2^PWM_BITS-2 and wraps to 0.
  - Shadow duty per channel is loaded from cur only when counter==0; there is no mid-period change.
  - pwm_out[i] <= (counter < shadow[i]), registered, one cycle after compare.
  - duty 0 gives constant low; duty 2^PWM_BITS-1 gives constant high.
- duty_bus reflects cur (pre-shadow) directly.
- Reset mid-ramp forces all outputs low immediately (asynchronous).

Optional Feature:
- Macro: DRIVE_RAMP_WATCHDOG_EN.
- Defined:
  - Watchdog counter increments on each tick and clears on any cmd_valid.
  - At WDT_TICKS it forces mode<=STOP (a controlled ramp down, not BRAKE) and saturates there until the next cmd_valid.
  - Adds output wdt_trip (1 bit), high while the watchdog is expired.
  - HOLD is also overridden by expiry.
- Undefined: no watchdog logic; the wdt_trip port is absent; mode persists indefinitely.

Test Plan:
- Ramp up: CH=2, TICK_DIV=10 (sim), RAMP_STEP=8, RUN with targets 20/100 -> ch0 duty 8, 16, 20 then stops; ch1 reaches 100 after 13 ticks; busy drops the cycle state hits AT_TGT.
- Ramp down and STOP: from 100/100 issue STOP -> duty decreases 8 per tick to 0 (13 ticks); state RAMP then IDLE; pwm_out low for the full period after the shadow load.
- BRAKE and collision: at duty 96, assert BRAKE on a tick cycle -> duty_bus=0 next cycle; no step to 88 or 104 appears; state IDLE.
- PWM shape: PWM_BITS=4, duty 5 -> pwm_out high 5 of every 15 clocks. Duty change mid-period applies only from the next counter==0. Duty 15 -> constant high.
- HOLD, reset, watchdog: HOLD mid-ramp at 48 -> duty stays 48 over 20 ticks, state FROZEN. Reset low mid-ramp -> all outputs 0 asynchronously. With DRIVE_RAMP_WATCHDOG_EN and WDT_TICKS=5, no cmd for 5 ticks -> wdt_trip=1 and ramp to 0; a cmd_valid clears wdt_trip.
